// File: rtl/proc_ctrl_pkg.sv
// Shared types for the multi-cycle processor control path: FSM state encodings,
// decoded instruction classes and the default data-memory watchdog limit.
package proc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  // Encodings 5..7 are illegal and have no enumerator.
  typedef enum logic [2:0] {
    OP_ALU    = 3'd0,
    OP_LOAD   = 3'd1,
    OP_STORE  = 3'd2,
    OP_BRANCH = 3'd3,
    OP_HALT   = 3'd4
  } op_class_t;

  localparam int MEM_TIMEOUT_DEF = 15;

endpackage

// File: rtl/seq_watchdog.sv
// Data-memory watchdog: counts enabled cycles, clears on request, and flags the
// cycle in which one more unacknowledged cycle would reach MEM_TIMEOUT.
module seq_watchdog #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i)  cnt_q <= cnt_q + 8'd1;
  end

  // Terminal one cycle early so the FSM leaves MEM on the edge the count would hit the limit.
  assign tc_o = (cnt_q == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: turns the decoded instruction class into per-cycle
// datapath enables, handshakes with data memory and counts retired instructions.
module multicycle_sequencer
  import proc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             halt_req,
  input  logic [2:0]       op_class,
  input  logic             branch_taken,
  input  logic             mem_ack,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             ir_we,
  output logic             flags_we,
  output logic             rf_we,
  output logic             rf_src_mem,
  output logic             mem_req,
  output logic             mem_we,
  output logic             busy,
  output logic             halted,
  output logic             fault,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired_cnt
);

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;
  logic             in_mem;
  logic             wd_tc;

  assign in_mem = (state_q == S_MEM);

  seq_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wd (
    .clk   (clk),
    .rst   (rst),
    .clr_i (!in_mem || mem_ack),
    .en_i  (in_mem && !mem_ack),
    .tc_o  (wd_tc)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        op_d = op_class;
        case (op_class)
          OP_ALU, OP_LOAD, OP_STORE, OP_BRANCH: state_d = S_EXEC;
          OP_HALT:                              state_d = S_HALT;
          default:                              state_d = S_FAULT;
        endcase
      end
      S_EXEC: begin
        case (op_q)
          OP_ALU:             state_d = S_WB;
          OP_LOAD, OP_STORE:  state_d = S_MEM;
          OP_BRANCH:          retire  = 1'b1;
          default:            state_d = S_FAULT;
        endcase
      end
      S_MEM: begin
        // An ack in the limit cycle still completes the access.
        if (mem_ack) begin
          if (op_q == OP_STORE) retire  = 1'b1;
          else                  state_d = S_WB;
        end else if (wd_tc) begin
          state_d = S_FAULT;
        end
      end
      S_WB:     retire = 1'b1;
      S_HALT:   if (run && !halt_req) state_d = S_FETCH;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FAULT;
    endcase
    // Instruction boundary: halt_req is only honoured here, never mid-instruction.
    if (retire) state_d = halt_req ? S_HALT : S_FETCH;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      if (retire && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    pc_we      = 1'b0;
    pc_sel     = 1'b0;
    ir_we      = 1'b0;
    flags_we   = 1'b0;
    rf_we      = 1'b0;
    rf_src_mem = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;
    case (state_q)
      S_FETCH: begin
        busy  = 1'b1;
        ir_we = 1'b1;
      end
      S_DECODE: busy = 1'b1;
      S_EXEC: begin
        busy     = 1'b1;
        flags_we = (op_q == OP_ALU);
        pc_we    = (op_q == OP_BRANCH);
        pc_sel   = (op_q == OP_BRANCH) && branch_taken;
      end
      S_MEM: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        mem_we  = (op_q == OP_STORE);
        pc_we   = (op_q == OP_STORE) && mem_ack;
      end
      S_WB: begin
        busy       = 1'b1;
        rf_we      = 1'b1;
        rf_src_mem = (op_q == OP_LOAD);
        pc_we      = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: ;
    endcase
  end

  assign state_o     = state_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: an instruction-phase model checked on
// every cycle, plus hand-computed latencies, counts and reset expectations.
module tb_multicycle_sequencer;

  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic run = 1'b0, halt_req = 1'b0, branch_taken = 1'b0, mem_ack = 1'b0;
  logic [2:0] op_class = 3'd0;

  logic pc_we, pc_sel, ir_we, flags_we, rf_we, rf_src_mem, mem_req, mem_we, busy, halted, fault;
  logic [2:0]  state_o;
  logic [15:0] retired_cnt;

  logic b_pc_we, b_pc_sel, b_ir_we, b_flags_we, b_rf_we, b_rf_src_mem, b_mem_req, b_mem_we;
  logic b_busy, b_halted, b_fault;
  logic [2:0] b_state;
  logic [1:0] b_retired;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_sequencer #(.MEM_TIMEOUT(TMO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .run(run), .halt_req(halt_req), .op_class(op_class),
    .branch_taken(branch_taken), .mem_ack(mem_ack),
    .pc_we(pc_we), .pc_sel(pc_sel), .ir_we(ir_we), .flags_we(flags_we), .rf_we(rf_we),
    .rf_src_mem(rf_src_mem), .mem_req(mem_req), .mem_we(mem_we), .busy(busy),
    .halted(halted), .fault(fault), .state_o(state_o), .retired_cnt(retired_cnt)
  );

  multicycle_sequencer #(.MEM_TIMEOUT(TMO), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .run(run), .halt_req(halt_req), .op_class(op_class),
    .branch_taken(branch_taken), .mem_ack(mem_ack),
    .pc_we(b_pc_we), .pc_sel(b_pc_sel), .ir_we(b_ir_we), .flags_we(b_flags_we), .rf_we(b_rf_we),
    .rf_src_mem(b_rf_src_mem), .mem_req(b_mem_req), .mem_we(b_mem_we), .busy(b_busy),
    .halted(b_halted), .fault(b_fault), .state_o(b_state), .retired_cnt(b_retired)
  );

  // Model: machine mode plus position in the current instruction's phase list.
  localparam logic [1:0] MD_IDLE = 2'd0, MD_RUN = 2'd1, MD_HALT = 2'd2, MD_FLT = 2'd3;
  localparam logic [2:0] PH_F = 3'd0, PH_D = 3'd1, PH_E = 3'd2, PH_M = 3'd3, PH_W = 3'd4;

  typedef struct packed {
    logic [1:0]  mode;
    logic [2:0]  ph;
    logic [2:0]  op;
    logic [7:0]  mw;
    logic [31:0] ret;
  } mdl_t;

  mdl_t m = '0;

  function automatic mdl_t nxt(mdl_t c, logic r, logic h, logic [2:0] opc, logic ack);
    mdl_t n;
    logic done;
    n = c;
    done = 1'b0;
    case (c.mode)
      MD_IDLE: if (r) begin n.mode = MD_RUN; n.ph = PH_F; end
      MD_HALT: if (r && !h) begin n.mode = MD_RUN; n.ph = PH_F; end
      MD_RUN: begin
        case (c.ph)
          PH_F: n.ph = PH_D;
          PH_D: begin
            n.op = opc;
            if (opc == 3'd4)     n.mode = MD_HALT;
            else if (opc > 3'd4) n.mode = MD_FLT;
            else                 n.ph = PH_E;
          end
          PH_E: begin
            if (c.op == 3'd3)      done = 1'b1;
            else if (c.op == 3'd0) n.ph = PH_W;
            else begin n.ph = PH_M; n.mw = 8'd0; end
          end
          PH_M: begin
            if (ack) begin
              if (c.op == 3'd2) done = 1'b1;
              else              n.ph = PH_W;
            end else if (c.mw + 8'd1 == 8'(TMO)) n.mode = MD_FLT;
            else n.mw = c.mw + 8'd1;
          end
          default: done = 1'b1;
        endcase
      end
      default: ;
    endcase
    if (done) begin
      n.ret  = c.ret + 32'd1;
      n.mode = h ? MD_HALT : MD_RUN;
      n.ph   = PH_F;
    end
    return n;
  endfunction

  function automatic logic [2:0] exp_state(mdl_t c);
    case (c.mode)
      MD_IDLE: return 3'd0;
      MD_HALT: return 3'd6;
      MD_FLT:  return 3'd7;
      default: return c.ph + 3'd1;
    endcase
  endfunction

  // Order: pc_we pc_sel ir_we flags_we rf_we rf_src_mem mem_req mem_we busy halted fault
  function automatic logic [10:0] exp_outs(mdl_t c, logic bt, logic ack);
    logic [2:0] s;
    s = exp_state(c);
    return { (s == 3'd3 && c.op == 3'd3) || (s == 3'd4 && c.op == 3'd2 && ack) || s == 3'd5,
             s == 3'd3 && c.op == 3'd3 && bt,
             s == 3'd1,
             s == 3'd3 && c.op == 3'd0,
             s == 3'd5,
             s == 3'd5 && c.op == 3'd1,
             s == 3'd4,
             s == 3'd4 && c.op == 3'd2,
             s >= 3'd1 && s <= 3'd5,
             s == 3'd6,
             s == 3'd7 };
  endfunction

  function automatic int sat(logic [31:0] r, int w);
    int lim;
    lim = (1 << w) - 1;
    return (r > 32'(lim)) ? lim : int'(r);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= '0;
    else      m <= nxt(m, run, halt_req, op_class, mem_ack);
  end

  logic [10:0] dut_o;
  assign dut_o = {pc_we, pc_sel, ir_we, flags_we, rf_we, rf_src_mem, mem_req, mem_we, busy, halted, fault};

  always @(negedge clk) begin
    chk("outs",       32'(dut_o),       32'(exp_outs(m, branch_taken, mem_ack)));
    chk("state",      32'(state_o),     32'(exp_state(m)));
    chk("retired",    32'(retired_cnt), sat(m.ret, 16));
    chk("state_w2",   32'(b_state),     32'(exp_state(m)));
    chk("retired_w2", 32'(b_retired),   sat(m.ret, 2));
    chk("inv_we_req", 32'(mem_we & ~mem_req), 0);
    chk("inv_rf_mem", 32'(rf_we & mem_req),   0);
    chk("inv_pc_ir",  32'(pc_we & ir_we),     0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_st(input logic [2:0] s, input int budget);
    int n;
    n = 0;
    while (state_o != s && n < budget) begin
      tick();
      n++;
    end
    chk("wait_state", 32'(state_o), 32'(s));
  endtask

  // Runs one LOAD/STORE from a FETCH sample; ack in MEM cycle ack_at (0 = never).
  task automatic do_mem(input logic [2:0] op, input int ack_at, input logic hlt,
                        output int nreq, output int len);
    op_class = op;
    nreq = 0;
    len  = 0;
    do begin
      tick();
      len++;
      if (mem_req) begin
        nreq++;
        mem_ack = (nreq == ack_at);
        if (hlt) halt_req = 1'b1;
      end else begin
        mem_ack = 1'b0;
      end
    end while (state_o != 3'd1 && state_o != 3'd6 && state_o != 3'd7 && len < 60);
    mem_ack = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [2:0] seq [0:12];
    int alu_seq [0:4];
    int nreq, len;
    alu_seq = '{1, 2, 3, 5, 1};

    tick(); tick();
    chk("rst_state", 32'(state_o), 0);
    chk("rst_cnt",   32'(retired_cnt), 0);
    chk("rst_req",   32'(mem_req), 0);

    // ALU stream
    rst = 1'b1; run = 1'b1; op_class = 3'd0;
    wait_st(3'd1, 5);
    for (int i = 0; i <= 12; i++) begin
      seq[i] = state_o;
      if (i == 2) chk("alu_flags_we", 32'(flags_we), 1);
      if (i == 3) chk("alu_rf_we", 32'(rf_we), 1);
      if (i < 12) tick();
    end
    for (int i = 0; i < 5; i++) chk("alu_seq", 32'(seq[i]), alu_seq[i]);
    chk("alu_retired3", 32'(retired_cnt), 3);

    // BRANCH taken then not taken
    op_class = 3'd3; branch_taken = 1'b1;
    tick(); tick();
    chk("br1_pc_we", 32'(pc_we), 1);
    chk("br1_pc_sel", 32'(pc_sel), 1);
    tick();
    chk("br1_len3", 32'(state_o), 1);
    branch_taken = 1'b0;
    tick(); tick();
    chk("br0_pc_we", 32'(pc_we), 1);
    chk("br0_pc_sel", 32'(pc_sel), 0);
    tick();
    chk("br0_len3", 32'(state_o), 1);

    // LOAD acked in third MEM cycle
    do_mem(3'd1, 3, 1'b0, nreq, len);
    chk("ld_req_cycles", nreq, 3);
    chk("ld_len", len, 7);
    chk("ld_retired", 32'(retired_cnt), 6);

    // STORE never acked -> FAULT
    do_mem(3'd2, 0, 1'b0, nreq, len);
    chk("st_to_req_cycles", nreq, 15);
    chk("st_to_state", 32'(state_o), 7);
    tick(); tick(); tick();
    chk("st_to_sticky", 32'(fault), 1);
    rst = 1'b0;
    tick();
    chk("rst2_cnt", 32'(retired_cnt), 0);
    rst = 1'b1;
    wait_st(3'd1, 4);

    // STORE acked exactly on the limit cycle
    do_mem(3'd2, 15, 1'b0, nreq, len);
    chk("st15_req_cycles", nreq, 15);
    chk("st15_len", len, 18);
    chk("st15_no_fault", 32'(state_o), 1);
    chk("st15_retired", 32'(retired_cnt), 1);

    // halt_req during LOAD's MEM: load retires, then HALT
    do_mem(3'd1, 1, 1'b1, nreq, len);
    chk("hlt_halted", 32'(halted), 1);
    chk("hlt_retired", 32'(retired_cnt), 2);
    tick();
    chk("hlt_hold", 32'(state_o), 6);
    halt_req = 1'b0;
    tick();
    chk("hlt_resume", 32'(state_o), 1);

    // Illegal op class
    op_class = 3'd6;
    tick(); tick();
    chk("ill_state", 32'(state_o), 7);
    chk("ill_fault", 32'(fault), 1);

    // Asynchronous reset in the middle of MEM
    rst = 1'b0; tick(); rst = 1'b1; op_class = 3'd0;
    wait_st(3'd1, 4);
    tick(); tick(); tick(); tick();
    chk("pre_rst_cnt", 32'(retired_cnt), 1);
    op_class = 3'd2;
    tick(); tick(); tick(); tick();
    chk("mid_mem_req", 32'(mem_req), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_req", 32'(mem_req), 0);
    chk("async_state", 32'(state_o), 0);
    chk("async_cnt", 32'(retired_cnt), 0);
    chk("async_cnt_w2", 32'(b_retired), 0);

    // Saturation of the narrow counter after 5 ALU instructions
    tick();
    op_class = 3'd0; rst = 1'b1;
    wait_st(3'd1, 4);
    repeat (20) tick();
    chk("sat_cnt16", 32'(retired_cnt), 5);
    chk("sat_cnt2", 32'(b_retired), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
